ddr3_req_queue: RTL and testbench
=================================

// Module: ddr3_req_queue
//
// PURPOSE
//  CPU-side request queue that sits directly upstream of the DDR3 memory controller.
//  Buffers up to DEPTH read/write requests and presents them one at a time on the
//  controller's ADDR_VALID/CMD_RDY handshake. Holds write data stable for the whole
//  burst, captures 64-bit read data a fixed latency after issue, and returns it to
//  the CPU as a one-cycle response.
//
// PARAMETERS
//  DEPTH      4    queue entries; power of two, >= 2
//  BA_W       3    bank address width
//  ADDR_W     15   row address width
//  COL_W      10   column address width
//  DATA_W     64   burst data width (4 beats x 16b at the controller)
//  RD_LAT     6    cycles from issue-accept to valid cont_rd_data; >= 1
//  WR_CYC     4    cycles write data is held after issue-accept; >= 1
//
// PORTS
//  cpu_clk        in   1       sole clock, rising edge
//  reset          in   1       synchronous, active-high
//  req_valid      in   1       CPU request present
//  req_ready      out  1       queue can accept (= count < DEPTH)
//  req_cmd        in   1       1 = read, 0 = write
//  req_ba         in   BA_W    bank
//  req_addr       in   ADDR_W  row
//  req_col        in   COL_W   column
//  req_wr_data    in   DATA_W  write data (ignored for reads)
//  rsp_valid      out  1       one-cycle pulse: read data available
//  rsp_data       out  DATA_W  read data, valid only when rsp_valid
//  cont_cmd_rdy   in   1       controller ready for a new command
//  cont_addr_valid out 1       head entry presented to controller
//  cont_cmd       out  1       head command (1 = read)
//  cont_ba        out  BA_W    head bank
//  cont_addr      out  ADDR_W  head row
//  cont_col       out  COL_W   head column
//  cont_wr_data   out  DATA_W  head write data
//  cont_rd_data   in   DATA_W  assembled read data from controller
//  q_count        out  $clog2(DEPTH+1)  current occupancy
//
// BEHAVIOUR
//  Reset (sync, high): wr_ptr = rd_ptr = count = 0; state = IDLE; lat_cnt = 0;
//   rsp_valid = 0; rsp_data = 0; cont_addr_valid = 0; cont_* address/data = 0.
//   Asserting reset mid-burst drops the in-flight and all queued requests; no rsp_valid.
//  Push: req_valid && req_ready -> store entry at wr_ptr; wr_ptr wraps at DEPTH.
//  Pop: happens on the cycle BUSY completes (see FSM); rd_ptr wraps at DEPTH.
//   Push and pop in the same cycle -> count unchanged. Full -> req_ready = 0 and
//   the push is ignored. Pop never occurs when count == 0.
//  FSM (registered state):
//   IDLE:  count != 0 -> ISSUE (the head is presented on the next cycle).
//   ISSUE: cont_addr_valid = 1; cont_* driven from the head entry, held stable until
//          accept. Accept = cont_addr_valid && cont_cmd_rdy -> BUSY, lat_cnt = 0.
//   BUSY:  cont_addr_valid = 0; cont_* still driven from the head (wr_data held).
//          lat_cnt++ each cycle. Limit L = RD_LAT for reads, WR_CYC for writes.
//          When lat_cnt == L-1:
//            read  -> rsp_data <= cont_rd_data, rsp_valid = 1 for the next cycle only.
//            Pop the head in both cases.
//            count after pop != 0 -> ISSUE, else -> IDLE.
//  Ordering: strictly in order; at most one request is outstanding at the controller.
//  Min issue-to-issue spacing = L + 1 cycles. A request pushed into an empty queue
//   has cont_addr_valid high 2 cycles after the push edge.
//  cont_addr_valid is never high in IDLE or BUSY. rsp_valid is never high for writes.
//
// TESTING
//  1. Reset, push write (ba=1,addr=0x10,col=0x8,data=0xA5A5_0000_FFFF_1234), cmd_rdy=1
//     -> cont_addr_valid high 1 cycle, cont_wr_data stable for WR_CYC cycles, no rsp_valid.
//  2. Push read, cont_rd_data=0xDEAD_BEEF_0123_4567 -> rsp_valid exactly one cycle,
//     RD_LAT+1 cycles after accept, with rsp_data=0xDEAD_BEEF_0123_4567.
//  3. cmd_rdy=0, push 5 requests with DEPTH=4 -> req_ready low after 4, q_count=4,
//     5th dropped; cont_* unchanged while stalled; raising cmd_rdy drains in order.
//  4. Push on the same edge as a BUSY pop at count=4 -> push refused (ready=0);
//     at count=2 -> both happen, q_count stays 2; pointers wrap after 4 entries.
//  5. Assert reset 2 cycles into a read BUSY -> no rsp_valid, q_count=0, all outputs 0.
//  6. Back-to-back read, write, read -> responses in order; write gives no rsp.

Source files
------------

// File: rtl/ddr3_req_queue.sv
// In-order request queue in front of the DDR3 controller. It issues one command at a
// time, holds it for the burst, and returns read data as a single-cycle response.
module ddr3_req_queue #(
  parameter int DEPTH  = 4,
  parameter int BA_W   = 3,
  parameter int ADDR_W = 15,
  parameter int COL_W  = 10,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 6,
  parameter int WR_CYC = 4
) (
  input  logic                       cpu_clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_cmd,
  input  logic [BA_W-1:0]            req_ba,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [COL_W-1:0]           req_col,
  input  logic [DATA_W-1:0]          req_wr_data,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  input  logic                       cont_cmd_rdy,
  output logic                       cont_addr_valid,
  output logic                       cont_cmd,
  output logic [BA_W-1:0]            cont_ba,
  output logic [ADDR_W-1:0]          cont_addr,
  output logic [COL_W-1:0]           cont_col,
  output logic [DATA_W-1:0]          cont_wr_data,
  input  logic [DATA_W-1:0]          cont_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int LMAX = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
  localparam int LW   = $clog2(LMAX+1);

  typedef struct packed {
    logic              cmd;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  entry_t            mem_q [DEPTH];
  entry_t            head;
  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d, lim_m1;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              push, pop;

  assign head      = mem_q[rd_ptr_q];
  assign req_ready = (count_q != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign lim_m1    = head.cmd ? LW'(RD_LAT-1) : LW'(WR_CYC-1);

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    pop         = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE:  if (count_q != '0) state_d = ISSUE;
      ISSUE: if (cont_cmd_rdy) begin
        state_d   = BUSY;
        lat_cnt_d = '0;
      end
      BUSY: begin
        if (lat_cnt_q == lim_m1) begin
          pop = 1'b1;
          if (head.cmd) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = cont_rd_data;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Completion decides between the next issue and idle using post-pop occupancy.
    if (pop) state_d = (count_d != '0) ? ISSUE : IDLE;

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lat_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lat_cnt_q   <= lat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Storage needs no reset: outputs are gated by the FSM state.
  always_ff @(posedge cpu_clk) begin
    if (!reset && push)
      mem_q[wr_ptr_q] <= '{cmd: req_cmd, ba: req_ba, addr: req_addr,
                           col: req_col, data: req_wr_data};
  end

  always_comb begin
    cont_addr_valid = (state_q == ISSUE);
    cont_cmd        = 1'b0;
    cont_ba         = '0;
    cont_addr       = '0;
    cont_col        = '0;
    cont_wr_data    = '0;
    if (state_q != IDLE) begin
      cont_cmd     = head.cmd;
      cont_ba      = head.ba;
      cont_addr    = head.addr;
      cont_col     = head.col;
      cont_wr_data = head.data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign q_count   = count_q;
endmodule

// File: tb/tb_ddr3_req_queue.sv
// Directed bench for ddr3_req_queue with default parameters (DEPTH=4, RD_LAT=6, WR_CYC=4).
module tb_ddr3_req_queue;
  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_cmd;
  logic [2:0]  req_ba;
  logic [14:0] req_addr;
  logic [9:0]  req_col;
  logic [63:0] req_wr_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        cont_cmd_rdy, cont_addr_valid, cont_cmd;
  logic [2:0]  cont_ba;
  logic [14:0] cont_addr;
  logic [9:0]  cont_col;
  logic [63:0] cont_wr_data, cont_rd_data;
  logic [2:0]  q_count;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] RD_BASE = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] WR_BASE = 64'hC0DE_0000_0000_0000;

  // Read data tagged by the head column so out-of-order returns are visible.
  assign cont_rd_data = RD_BASE ^ {54'b0, cont_col};

  ddr3_req_queue dut (
    .cpu_clk(cpu_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_ba(req_ba), .req_addr(req_addr), .req_col(req_col), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cont_cmd_rdy(cont_cmd_rdy), .cont_addr_valid(cont_addr_valid), .cont_cmd(cont_cmd),
    .cont_ba(cont_ba), .cont_addr(cont_addr), .cont_col(cont_col),
    .cont_wr_data(cont_wr_data), .cont_rd_data(cont_rd_data), .q_count(q_count)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_req(input logic cmd, input logic [9:0] col);
    req_valid   = 1'b1;
    req_cmd     = cmd;
    req_ba      = 3'd2;
    req_addr    = 15'h0040;
    req_col     = col;
    req_wr_data = WR_BASE | 64'(col);
  endtask

  task automatic wait_av(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++)
      if (!ok) begin
        if (cont_addr_valid) ok = 1'b1;
        else tick();
      end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", q_count); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (cont_addr_valid !== 1'b0) begin bad++; $display("FAIL rst_av got=%b exp=0", cont_addr_valid); end
    total++; if (rsp_valid !== 1'b0 || rsp_data !== 64'd0) begin bad++; $display("FAIL rst_rsp got=%b/%h exp=0/0", rsp_valid, rsp_data); end
    total++; if (cont_wr_data !== 64'd0 || cont_col !== 10'd0) begin bad++; $display("FAIL rst_cont got=%h/%h exp=0/0", cont_wr_data, cont_col); end
  endtask

  task automatic test_write();
    cont_cmd_rdy = 1'b1;
    req_valid = 1'b1; req_cmd = 1'b0; req_ba = 3'd1; req_addr = 15'h10; req_col = 10'h8;
    req_wr_data = 64'hA5A5_0000_FFFF_1234;
    tick();
    req_valid = 1'b0;
    total++; if (q_count !== 3'd1 || cont_addr_valid !== 1'b0) begin bad++; $display("FAIL wr_push got=%0d/%b exp=1/0", q_count, cont_addr_valid); end
    tick();
    total++; if (cont_addr_valid !== 1'b1) begin bad++; $display("FAIL wr_issue_av got=%b exp=1", cont_addr_valid); end
    total++; if (cont_cmd !== 1'b0 || cont_ba !== 3'd1 || cont_addr !== 15'h10 || cont_col !== 10'h8) begin
      bad++; $display("FAIL wr_issue_fields got=%b/%h/%h/%h exp=0/1/10/8", cont_cmd, cont_ba, cont_addr, cont_col); end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (cont_wr_data !== 64'hA5A5_0000_FFFF_1234 || cont_addr_valid !== 1'b0 || rsp_valid !== 1'b0) begin
        bad++; $display("FAIL wr_busy%0d got=%h/%b/%b exp=a5a50000ffff1234/0/0", i, cont_wr_data, cont_addr_valid, rsp_valid); end
      tick();
    end
    total++; if (q_count !== 3'd0 || cont_addr_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL wr_done got=%0d/%b/%b exp=0/0/0", q_count, cont_addr_valid, rsp_valid); end
  endtask

  task automatic test_read();
    cont_cmd_rdy = 1'b1;
    set_req(1'b1, 10'd0);
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (cont_addr_valid !== 1'b1 || cont_cmd !== 1'b1) begin bad++; $display("FAIL rd_issue got=%b/%b exp=1/1", cont_addr_valid, cont_cmd); end
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (rsp_valid !== (i == 6)) begin bad++; $display("FAIL rd_rsp_t%0d got=%b exp=%b", i, rsp_valid, (i == 6)); end
      if (i == 6) begin
        total++; if (rsp_data !== RD_BASE) begin bad++; $display("FAIL rd_data got=%h exp=%h", rsp_data, RD_BASE); end
      end
    end
  endtask

  task automatic test_full();
    logic ok;
    cont_cmd_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin set_req(1'b0, 10'(k)); tick(); end
    total++; if (q_count !== 3'd4 || req_ready !== 1'b0) begin bad++; $display("FAIL full_cnt got=%0d/%b exp=4/0", q_count, req_ready); end
    set_req(1'b0, 10'd5); tick(); req_valid = 1'b0;
    total++; if (q_count !== 3'd4) begin bad++; $display("FAIL full_drop got=%0d exp=4", q_count); end
    tick(); tick(); tick();
    total++; if (cont_addr_valid !== 1'b1 || cont_col !== 10'd1 || cont_wr_data !== (WR_BASE | 64'd1)) begin
      bad++; $display("FAIL full_stall got=%b/%h/%h exp=1/1/%h", cont_addr_valid, cont_col, cont_wr_data, WR_BASE | 64'd1); end
    cont_cmd_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_av(ok);
      total++; if (ok !== 1'b1 || cont_col !== 10'(k)) begin bad++; $display("FAIL drain%0d got=%b/%0d exp=1/%0d", k, ok, cont_col, k); end
      tick();
    end
    for (int i = 0; i < 5; i++) tick();
    total++; if (q_count !== 3'd0 || cont_addr_valid !== 1'b0) begin bad++; $display("FAIL drain_end got=%0d/%b exp=0/0", q_count, cont_addr_valid); end
  endtask

  task automatic test_simul();
    logic ok;
    cont_cmd_rdy = 1'b0;
    for (int k = 10; k <= 13; k++) begin set_req(1'b0, 10'(k)); tick(); end
    req_valid = 1'b0;
    cont_cmd_rdy = 1'b1; tick(); cont_cmd_rdy = 1'b0;
    tick(); tick(); tick();
    total++; if (req_ready !== 1'b0 || q_count !== 3'd4) begin bad++; $display("FAIL sim_full got=%b/%0d exp=0/4", req_ready, q_count); end
    set_req(1'b0, 10'd14); tick(); req_valid = 1'b0;
    total++; if (q_count !== 3'd3 || cont_addr_valid !== 1'b1 || cont_col !== 10'd11) begin
      bad++; $display("FAIL sim_refuse got=%0d/%b/%0d exp=3/1/11", q_count, cont_addr_valid, cont_col); end
    cont_cmd_rdy = 1'b1; tick(); cont_cmd_rdy = 1'b0;
    tick(); tick(); tick(); tick();
    cont_cmd_rdy = 1'b1; tick(); cont_cmd_rdy = 1'b0;
    tick(); tick(); tick();
    total++; if (q_count !== 3'd2) begin bad++; $display("FAIL sim_pre got=%0d exp=2", q_count); end
    set_req(1'b0, 10'd15); tick(); req_valid = 1'b0;
    total++; if (q_count !== 3'd2 || cont_col !== 10'd13) begin bad++; $display("FAIL sim_both got=%0d/%0d exp=2/13", q_count, cont_col); end
    cont_cmd_rdy = 1'b1;
    wait_av(ok);
    total++; if (ok !== 1'b1 || cont_col !== 10'd13) begin bad++; $display("FAIL sim_d13 got=%b/%0d exp=1/13", ok, cont_col); end
    tick();
    wait_av(ok);
    total++; if (ok !== 1'b1 || cont_col !== 10'd15 || cont_wr_data !== (WR_BASE | 64'd15)) begin
      bad++; $display("FAIL sim_wrap got=%b/%0d/%h exp=1/15/%h", ok, cont_col, cont_wr_data, WR_BASE | 64'd15); end
    for (int i = 0; i < 6; i++) tick();
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL sim_end got=%0d exp=0", q_count); end
  endtask

  task automatic test_reset_mid();
    int seen;
    cont_cmd_rdy = 1'b1;
    set_req(1'b1, 10'd0); tick();
    set_req(1'b1, 10'd0); tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (q_count !== 3'd2 || cont_addr_valid !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0d/%b exp=2/0", q_count, cont_addr_valid); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (q_count !== 3'd0 || cont_addr_valid !== 1'b0 || cont_cmd !== 1'b0 || cont_wr_data !== 64'd0 || rsp_data !== 64'd0) begin
      bad++; $display("FAIL mid_rst got=%0d/%b/%b/%h/%h exp=0/0/0/0/0", q_count, cont_addr_valid, cont_cmd, cont_wr_data, rsp_data); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid === 1'b1 || cont_addr_valid === 1'b1) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_quiet got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] d [4];
    cont_cmd_rdy = 1'b1;
    set_req(1'b1, 10'd1); tick();
    set_req(1'b0, 10'd2); tick();
    set_req(1'b1, 10'd3); tick();
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid === 1'b1) begin
        if (n < 4) d[n] = rsp_data;
        n++;
      end
      tick();
    end
    total++; if (n !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n); end
    if (n >= 2) begin
      total++; if (d[0] !== (RD_BASE ^ 64'd1)) begin bad++; $display("FAIL b2b_first got=%h exp=%h", d[0], RD_BASE ^ 64'd1); end
      total++; if (d[1] !== (RD_BASE ^ 64'd3)) begin bad++; $display("FAIL b2b_second got=%h exp=%h", d[1], RD_BASE ^ 64'd3); end
    end
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL b2b_end got=%0d exp=0", q_count); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_cmd = 1'b0; req_ba = '0; req_addr = '0;
    req_col = '0; req_wr_data = '0; cont_cmd_rdy = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_full();
    test_simul();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
